// File: rtl/vga_bus_arbiter_if.sv
// Bus bundle for the VGA/CPU video RAM arbiter.
// Names match the arbiter's port list, seen from the arbiter.
//   slave  : the arbiter itself (takes i_*, drives o_*)
//   master : the environment (VGA controller, CPU, RAM model)
// Signal groups:
//   vgamaster_* : VGA fetch port (addr, cs, look-ahead access, read data)
//   cpu_*       : CPU port (addr, wdata, cs, we, rdata, ack, starved)
//   mem_*       : synchronous RAM port (addr, wdata, rdata, cs, we)
interface vga_bus_arbiter_if;
   logic [15:0] i_vgamaster_addr;
   logic        i_vgamaster_cs;
   logic        i_vgamaster_access;
   logic [7:0]  o_vgamaster_dat;

   logic [15:0] i_cpu_addr;
   logic [7:0]  i_cpu_dat;
   logic        i_cpu_cs;
   logic        i_cpu_we;
   logic [7:0]  o_cpu_dat;
   logic        o_cpu_ack;
   logic        o_cpu_starved;

   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_dat;
   logic [7:0]  i_mem_dat;
   logic        o_mem_cs;
   logic        o_mem_we;

   modport slave (
      input  i_vgamaster_addr, i_vgamaster_cs, i_vgamaster_access,
      output o_vgamaster_dat,
      input  i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
      output o_cpu_dat, o_cpu_ack, o_cpu_starved,
      output o_mem_addr, o_mem_dat, o_mem_cs, o_mem_we,
      input  i_mem_dat
   );

   modport master (
      output i_vgamaster_addr, i_vgamaster_cs, i_vgamaster_access,
      input  o_vgamaster_dat,
      output i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we,
      input  o_cpu_dat, o_cpu_ack, o_cpu_starved,
      input  o_mem_addr, o_mem_dat, o_mem_cs, o_mem_we,
      output i_mem_dat
   );
endinterface

// File: rtl/vga_bus_arbiter.sv
// Video RAM arbiter: owns the single 8-bit synchronous RAM port (1-cycle
// read latency). The VGA fetch master always wins; CPU requests are slotted
// into cycles where VGA neither strobes cs nor announces access for the
// next cycle. Each CPU transfer ends with a one-cycle ack.
// Ports:
//   i_clk      : system/pixel clock
//   i_reset_n  : asynchronous active-low reset
//   bus        : vga_bus_arbiter_if.slave (VGA, CPU and RAM signal groups)
// Parameter:
//   WAIT_LIMIT : stall cycles one CPU request may take before o_cpu_starved
//
// state | meaning
// IDLE  | free to grant a pending CPU request
// ACK   | CPU access issued last cycle; ack pulses, read data on i_mem_dat
module vga_bus_arbiter #(
   parameter logic [7:0] WAIT_LIMIT = 8'd16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   vga_bus_arbiter_if.slave      bus
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        owner_cpu_q, owner_cpu_d;
   logic [7:0]  cpu_rdat_q, cpu_rdat_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        starved_q, starved_d;
   logic        cpu_grant;
   logic        cpu_stall;

   // Reset gates the grant so the RAM is never selected while held in reset.
   assign cpu_grant = i_reset_n & bus.i_cpu_cs & (state_q == IDLE) &
                      ~bus.i_vgamaster_cs & ~bus.i_vgamaster_access;
   assign cpu_stall = bus.i_cpu_cs & (state_q == IDLE) & ~cpu_grant;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         owner_cpu_q <= 1'b0;
         cpu_rdat_q  <= 8'h00;
         wait_cnt_q  <= 8'h00;
         starved_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_cpu_q <= owner_cpu_d;
         cpu_rdat_q  <= cpu_rdat_d;
         wait_cnt_q  <= wait_cnt_d;
         starved_q   <= starved_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_cpu_d = 1'b0;
      cpu_rdat_d  = cpu_rdat_q;
      wait_cnt_d  = wait_cnt_q;
      starved_d   = starved_q;

      case (state_q)
         IDLE: begin
            if (cpu_grant) begin
               state_d     = ACK;
               // Remember it was a read so only reads refresh cpu_rdat_q.
               owner_cpu_d = ~bus.i_cpu_we;
            end
         end
         ACK: begin
            state_d = IDLE;
            if (owner_cpu_q) begin
               cpu_rdat_d = bus.i_mem_dat;
            end
         end
         default: state_d = IDLE;
      endcase

      if (cpu_grant) begin
         wait_cnt_d = 8'h00;
      end else if (cpu_stall) begin
         if (wait_cnt_q == WAIT_LIMIT) begin
            starved_d = 1'b1;
         end
         if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'h01;
         end
      end
   end

   assign bus.o_mem_cs   = i_reset_n & (bus.i_vgamaster_cs | cpu_grant);
   assign bus.o_mem_we   = cpu_grant & bus.i_cpu_we;
   assign bus.o_mem_addr = bus.i_vgamaster_cs ? bus.i_vgamaster_addr :
                           cpu_grant          ? bus.i_cpu_addr       : 16'h0000;
   assign bus.o_mem_dat  = bus.i_cpu_dat;

   // RAM latency lines up with the VGA sampling the cycle after its cs.
   assign bus.o_vgamaster_dat = bus.i_mem_dat;

   assign bus.o_cpu_ack     = (state_q == ACK);
   assign bus.o_cpu_dat     = (state_q == ACK) ? bus.i_mem_dat : cpu_rdat_q;
   assign bus.o_cpu_starved = starved_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
module tb_vga_bus_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   acc_cnt  = 0;

   logic [7:0] ram [0:65535];
   logic [7:0] mem_rd;

   vga_bus_arbiter_if bus ();

   vga_bus_arbiter #(.WAIT_LIMIT(8'd16)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model, one cycle read latency.
   always @(posedge clk) begin
      if (bus.o_mem_cs) begin
         acc_cnt <= acc_cnt + 1;
         if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_dat;
         else              mem_rd <= ram[bus.o_mem_addr];
      end
   end
   assign bus.i_mem_dat = mem_rd;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = a; bus.i_cpu_dat = d;
      next_cycle();
      next_cycle();
      bus.i_cpu_cs = 1'b0; bus.i_cpu_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_vgamaster_addr = 16'h0000; bus.i_vgamaster_cs = 1'b1; bus.i_vgamaster_access = 1'b0;
      bus.i_cpu_addr = 16'h0000; bus.i_cpu_dat = 8'h00; bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b1;
      mem_rd = 8'h00;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b0) begin n_errors++; $display("FAIL rst_mem_cs got=%b exp=0", bus.o_mem_cs); end
      n_checks++; if (bus.o_mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.o_mem_we); end
      n_checks++; if (bus.o_cpu_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack got=%b exp=0", bus.o_cpu_ack); end
      n_checks++; if (bus.o_cpu_starved !== 1'b0) begin n_errors++; $display("FAIL rst_starved got=%b exp=0", bus.o_cpu_starved); end
      n_checks++; if (bus.o_cpu_dat !== 8'h00) begin n_errors++; $display("FAIL rst_cpu_dat got=%h exp=00", bus.o_cpu_dat); end
      next_cycle();
      bus.i_vgamaster_cs = 1'b0; bus.i_cpu_cs = 1'b0; bus.i_cpu_we = 1'b0;
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_write();
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 16'h1234; bus.i_cpu_dat = 8'hA5;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b1) begin n_errors++; $display("FAIL wr_mem_cs got=%b exp=1", bus.o_mem_cs); end
      n_checks++; if (bus.o_mem_we !== 1'b1) begin n_errors++; $display("FAIL wr_mem_we got=%b exp=1", bus.o_mem_we); end
      n_checks++; if (bus.o_mem_addr !== 16'h1234) begin n_errors++; $display("FAIL wr_addr got=%h exp=1234", bus.o_mem_addr); end
      n_checks++; if (bus.o_cpu_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_c0 got=%b exp=0", bus.o_cpu_ack); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack_c1 got=%b exp=1", bus.o_cpu_ack); end
      n_checks++; if (bus.o_mem_cs !== 1'b0) begin n_errors++; $display("FAIL wr_no_regrant got=%b exp=0", bus.o_mem_cs); end
      n_checks++; if (ram[16'h1234] !== 8'hA5) begin n_errors++; $display("FAIL wr_ram got=%h exp=a5", ram[16'h1234]); end
      next_cycle();
      bus.i_cpu_cs = 1'b0; bus.i_cpu_we = 1'b0;
      next_cycle();
   endtask

   task automatic test_read();
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h1234;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_we !== 1'b0) begin n_errors++; $display("FAIL rd_cs_we got=%b%b exp=10", bus.o_mem_cs, bus.o_mem_we); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL rd_ack got=%b exp=1", bus.o_cpu_ack); end
      n_checks++; if (bus.o_cpu_dat !== 8'hA5) begin n_errors++; $display("FAIL rd_dat_ack got=%h exp=a5", bus.o_cpu_dat); end
      next_cycle();
      bus.i_cpu_cs = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b0) begin n_errors++; $display("FAIL rd_ack_drop got=%b exp=0", bus.o_cpu_ack); end
      n_checks++; if (bus.o_cpu_dat !== 8'hA5) begin n_errors++; $display("FAIL rd_dat_hold got=%h exp=a5", bus.o_cpu_dat); end
      next_cycle();
      do_write(16'h2000, 8'h77);
      @(negedge clk);
      n_checks++; if (bus.o_cpu_dat !== 8'hA5) begin n_errors++; $display("FAIL rd_dat_after_wr got=%h exp=a5", bus.o_cpu_dat); end
      n_checks++; if (ram[16'h2000] !== 8'h77) begin n_errors++; $display("FAIL wr2_ram got=%h exp=77", ram[16'h2000]); end
      next_cycle();
   endtask

   task automatic test_vga_priority();
      do_write(16'h1000, 8'h3C);
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h1234;
      bus.i_vgamaster_access = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++; if (bus.o_mem_cs !== 1'b0 || bus.o_cpu_ack !== 1'b0) begin n_errors++; $display("FAIL pri_stall%0d cs=%b ack=%b exp=0,0", c, bus.o_mem_cs, bus.o_cpu_ack); end
         next_cycle();
      end
      bus.i_vgamaster_access = 1'b0; bus.i_vgamaster_cs = 1'b1; bus.i_vgamaster_addr = 16'h1000;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_we !== 1'b0) begin n_errors++; $display("FAIL pri_vga_cs got=%b%b exp=10", bus.o_mem_cs, bus.o_mem_we); end
      n_checks++; if (bus.o_mem_addr !== 16'h1000) begin n_errors++; $display("FAIL pri_vga_addr got=%h exp=1000", bus.o_mem_addr); end
      n_checks++; if (bus.o_cpu_ack !== 1'b0) begin n_errors++; $display("FAIL pri_ack_c2 got=%b exp=0", bus.o_cpu_ack); end
      next_cycle();
      bus.i_vgamaster_cs = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_addr !== 16'h1234) begin n_errors++; $display("FAIL pri_grant_c3 cs=%b addr=%h exp=1,1234", bus.o_mem_cs, bus.o_mem_addr); end
      n_checks++; if (bus.o_vgamaster_dat !== 8'h3C) begin n_errors++; $display("FAIL pri_vga_dat got=%h exp=3c", bus.o_vgamaster_dat); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1 || bus.o_cpu_dat !== 8'hA5) begin n_errors++; $display("FAIL pri_ack_c4 ack=%b dat=%h exp=1,a5", bus.o_cpu_ack, bus.o_cpu_dat); end
      next_cycle();
      bus.i_cpu_cs = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [4];
      logic [7:0]  dats  [4];
      int          acc0;
      addrs = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      dats  = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 4; k++) do_write(addrs[k], dats[k]);
      acc0 = acc_cnt;
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.i_cpu_addr = addrs[k];
         @(negedge clk);
         n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_addr !== addrs[k] || bus.o_cpu_ack !== 1'b0) begin
            n_errors++; $display("FAIL b2b_grant%0d cs=%b addr=%h ack=%b exp=1,%h,0", k, bus.o_mem_cs, bus.o_mem_addr, bus.o_cpu_ack, addrs[k]);
         end
         next_cycle();
         @(negedge clk);
         n_checks++; if (bus.o_cpu_ack !== 1'b1 || bus.o_mem_cs !== 1'b0 || bus.o_cpu_dat !== dats[k]) begin
            n_errors++; $display("FAIL b2b_ack%0d ack=%b cs=%b dat=%h exp=1,0,%h", k, bus.o_cpu_ack, bus.o_mem_cs, bus.o_cpu_dat, dats[k]);
         end
         next_cycle();
      end
      bus.i_cpu_cs = 1'b0;
      n_checks++; if (acc_cnt - acc0 !== 4) begin n_errors++; $display("FAIL b2b_accesses got=%0d exp=4", acc_cnt - acc0); end
      next_cycle();
   endtask

   task automatic test_starve();
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 16'h3000; bus.i_cpu_dat = 8'h5A;
      bus.i_vgamaster_access = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         n_checks++; if (bus.o_mem_cs !== 1'b0) begin n_errors++; $display("FAIL stv_stall%0d cs=%b exp=0", i, bus.o_mem_cs); end
         if (i == 16) begin
            n_checks++; if (bus.o_cpu_starved !== 1'b0) begin n_errors++; $display("FAIL stv_early got=%b exp=0", bus.o_cpu_starved); end
         end
         next_cycle();
      end
      bus.i_vgamaster_access = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.o_cpu_starved !== 1'b1) begin n_errors++; $display("FAIL stv_set got=%b exp=1", bus.o_cpu_starved); end
      n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_we !== 1'b1) begin n_errors++; $display("FAIL stv_grant got=%b%b exp=11", bus.o_mem_cs, bus.o_mem_we); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1 || bus.o_cpu_starved !== 1'b1) begin n_errors++; $display("FAIL stv_ack ack=%b stv=%b exp=1,1", bus.o_cpu_ack, bus.o_cpu_starved); end
      next_cycle();
      bus.i_cpu_cs = 1'b0; bus.i_cpu_we = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_starved !== 1'b1) begin n_errors++; $display("FAIL stv_sticky got=%b exp=1", bus.o_cpu_starved); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.o_cpu_starved !== 1'b0) begin n_errors++; $display("FAIL stv_clear got=%b exp=0", bus.o_cpu_starved); end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset_mid_ack();
      do_write(16'h1234, 8'hA5);
      bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h1234;
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1) begin n_errors++; $display("FAIL rma_ack got=%b exp=1", bus.o_cpu_ack); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.o_cpu_ack !== 1'b0 || bus.o_mem_cs !== 1'b0) begin n_errors++; $display("FAIL rma_abort ack=%b cs=%b exp=0,0", bus.o_cpu_ack, bus.o_mem_cs); end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.o_mem_cs !== 1'b1 || bus.o_mem_addr !== 16'h1234 || bus.o_cpu_ack !== 1'b0) begin
         n_errors++; $display("FAIL rma_regrant cs=%b addr=%h ack=%b exp=1,1234,0", bus.o_mem_cs, bus.o_mem_addr, bus.o_cpu_ack);
      end
      n_checks++; if (bus.o_cpu_dat !== 8'h00) begin n_errors++; $display("FAIL rma_rdat_clr got=%h exp=00", bus.o_cpu_dat); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.o_cpu_ack !== 1'b1 || bus.o_cpu_dat !== 8'hA5) begin n_errors++; $display("FAIL rma_reack ack=%b dat=%h exp=1,a5", bus.o_cpu_ack, bus.o_cpu_dat); end
      next_cycle();
      bus.i_cpu_cs = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_vga_priority();
      test_back_to_back();
      test_starve();
      test_reset_mid_ack();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_bus_arbiter.md
Name: vga_bus_arbiter

Overview:
- Multi-bus-master front end that owns the single 8-bit synchronous video RAM port (64 KiB, 1-cycle read latency).
- Serves the text-mode VGA fetch master with absolute priority, using its access look-ahead and chip-select.
- Interleaves stalled CPU reads/writes into the free cycles and returns an acknowledge for each.
- Sits between the CPU data bus, the VGA text controller's master port and the RAM.

Parameters:
- WAIT_LIMIT, 8'd16: CPU stall cycles for one request before o_cpu_starved sets.

Ports:
- i_clk  in  1  system/pixel clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_vgamaster_addr  in  16  VGA fetch address
- i_vgamaster_cs  in  1  VGA read strobe, this cycle
- i_vgamaster_access  in  1  VGA needs the port next cycle
- o_vgamaster_dat  out  8  read data to VGA
- i_cpu_addr  in  16  CPU address, held until ack
- i_cpu_dat  in  8  CPU write data, held until ack
- i_cpu_cs  in  1  CPU request, held until ack
- i_cpu_we  in  1  1 = write
- o_cpu_dat  out  8  CPU read data
- o_cpu_ack  out  1  one-cycle transfer-done pulse
- o_cpu_starved  out  1  sticky: a request waited more than WAIT_LIMIT cycles
- o_mem_addr  out  16  RAM address
- o_mem_dat  out  8  RAM write data
- i_mem_dat  in  8  RAM read data, valid the cycle after cs
- o_mem_cs  out  1  RAM select
- o_mem_we  out  1  RAM write enable

Behaviour:
- Reset (async, i_reset_n=0) clears: state=IDLE, r_owner_cpu=0, o_cpu_ack=0, r_cpu_rdat=0, wait counter=0, o_cpu_starved=0.
- While in reset: o_mem_cs=0 and o_mem_we=0 regardless of inputs.
- Grant, combinational: cpu_grant = i_cpu_cs & (state==IDLE) & ~i_vgamaster_cs & ~i_vgamaster_access.
- VGA has absolute priority: i_vgamaster_cs is never stalled or delayed.
- o_mem_cs = i_vgamaster_cs | cpu_grant.
- o_mem_we = cpu_grant & i_cpu_we.
- o_mem_addr = i_vgamaster_cs ? i_vgamaster_addr : cpu_grant ? i_cpu_addr : 16'h0.
- o_mem_dat = i_cpu_dat.
- o_vgamaster_dat = i_mem_dat, unregistered pass-through. VGA samples it the cycle after its cs, which matches the RAM latency.
- FSM states: IDLE and ACK.
  - IDLE -> ACK on cpu_grant.
  - ACK -> IDLE unconditionally after one cycle.
  - In ACK: o_cpu_ack=1 and no CPU grant, because i_cpu_cs still shows the finished request.
  - Maximum CPU throughput is 1 transfer per 2 cycles.
- Read data:
  - In the ACK cycle, o_cpu_dat = i_mem_dat, and r_cpu_rdat captures it.
  - In all other cycles, o_cpu_dat = r_cpu_rdat.
  - Writes also pulse ack; r_cpu_rdat is not updated by writes.
- A VGA cs during the ACK cycle is legal: RAM is pipelined, and the CPU data comes from the previous access.
- Wait counter, 8-bit:
  - Increments, saturating at 255, each IDLE cycle with i_cpu_cs=1 and no grant.
  - Clears on grant.
  - When counter == WAIT_LIMIT and a further stall occurs, o_cpu_starved sets; only reset clears it.
- Reset asserted mid-transfer aborts any pending ack. A granted write already has o_mem_we high in that cycle and may complete.
- With the standard VGA phase pattern, CPU grants occur only in the VGA phase-3 cycle and the gap cycles between characters. The VGA blocks 3 of every 8 cycles during visible lines.

Test Plan:
- Idle VGA, CPU write addr 16'h1234 dat 8'hA5 -> o_mem_cs=o_mem_we=1 and o_mem_addr=16'h1234 in cycle 0; o_cpu_ack=1 in cycle 1; RAM[16'h1234]=8'hA5.
- CPU read 16'h1234 after that write -> ack in cycle 1 with o_cpu_dat=8'hA5; o_cpu_dat stays 8'hA5 afterwards.
- CPU request held while i_vgamaster_access=1 for 2 cycles, then i_vgamaster_cs=1 for 1 cycle -> no CPU grant for 3 cycles; grant in cycle 3; VGA address 16'h1000 appears unmodified on o_mem_addr in cycle 2.
- i_cpu_cs held continuously with alternating addresses -> acks every 2nd cycle, never consecutive; each address accessed exactly once.
- VGA holds access/cs high for 17 cycles with WAIT_LIMIT=16 and a pending CPU request -> o_cpu_starved=1 after the 17th stall; it stays set after the grant; cleared only by i_reset_n=0.
- Assert i_reset_n=0 during the ACK cycle of a read -> o_cpu_ack=0 and o_mem_cs=0 immediately (async); after release, state=IDLE and the held request is re-granted.
